// File: rtl/intbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intbus_pkg
//  Description : Shared types and constants for the intbus master sequencer.
//                Command opcodes, sequencer FSM states, default bus widths
//                and well-known peripheral base addresses (word addresses).
//  Revision    : 1.0 - initial release
// ============================================================================
package intbus_pkg;

    localparam int INTBUS_ADDR_W = 32;
    localparam int INTBUS_DATA_W = 32;

    // Word address of the AXI performance counter block (byte 0x40180000 / 4).
    localparam logic [31:0] AXI_PERFORMANCE_BASE = 32'h1006_0000;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_WAIT  = 2'b10,
        OP_NOP   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RDWAIT  = 2'd2,
        ST_WAITCNT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/intbus_if.sv
`default_nettype none
// ============================================================================
//  Module      : intbus_if
//  Description : Command/response port plus intbus signals of the sequencer.
//                master : sequencer side (accepts commands, drives the bus)
//                slave  : controller + peripheral side
//  Signals     : cmd_valid/cmd_ready/cmd_op/cmd_base/cmd_offset/cmd_wdata,
//                rsp_valid/rsp_rdata, bus_addr/bus_wdata/bus_wr/bus_rd,
//                bus_rdata
//  Revision    : 1.0 - initial release
// ============================================================================
interface intbus_if
    import intbus_pkg::*;
#(
    parameter int ADDR_W = INTBUS_ADDR_W,
    parameter int DATA_W = INTBUS_DATA_W
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_offset;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_wr;
    logic              bus_rd;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_base, cmd_offset, cmd_wdata, bus_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, bus_addr, bus_wdata, bus_wr, bus_rd
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_base, cmd_offset, cmd_wdata, bus_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, bus_addr, bus_wdata, bus_wr, bus_rd
    );
endinterface
`default_nettype wire

// File: rtl/intbus_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : intbus_delay_cnt
//  Description : Loadable down-counter that saturates at zero. Shared by the
//                read-latency wait and the WAIT command.
//  Ports       : clk, rst      - clock, async active-high reset
//                i_load        - load i_load_val (has priority over i_dec)
//                i_dec         - decrement by one when non-zero
//                o_zero/o_one  - count equals 0 / equals 1
//  Revision    : 1.0 - initial release
// ============================================================================
module intbus_delay_cnt #(
    parameter int CNT_W = 16
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_load,
    input  wire  [CNT_W-1:0] i_load_val,
    input  wire              i_dec,
    output logic             o_zero,
    output logic             o_one
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == CNT_W'(1));
endmodule
`default_nettype wire

// File: rtl/intbus_interf.sv
`default_nettype none
// ============================================================================
//  Module      : intbus_interf
//  Description : intbus master sequencer. Executes READ / WRITE / WAIT / NOP
//                commands, one at a time, on the word-addressed intbus.
//  Ports       : clk  - clock, rising edge
//                rst  - async active-high reset (returns to the init state)
//                bus  - intbus_if.master: command/response port and intbus
//  Notes       : ADDR_W/DATA_W must match the connected interface instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module intbus_interf
    import intbus_pkg::*;
#(
    parameter int ADDR_W     = INTBUS_ADDR_W,
    parameter int DATA_W     = INTBUS_DATA_W,
    parameter int RD_LATENCY = 2,
    parameter int WAIT_W     = 16
) (
    input  wire       clk,
    input  wire       rst,
    intbus_if.master  bus
);
    // Counter must hold both a wait count and RD_LATENCY-1 (up to 6).
    localparam int              CNT_W     = (WAIT_W > 3) ? WAIT_W : 3;
    localparam logic [CNT_W-1:0] c_RD_LOAD = CNT_W'(RD_LATENCY - 1);

    state_t            r_state;
    op_t               r_op;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_bus_wr;
    logic              r_bus_rd;

    logic              w_hs;
    op_t               w_op;
    logic [WAIT_W-1:0] w_wait_n;
    logic [CNT_W-1:0]  w_wait_load;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_cnt_one;

    assign w_hs     = bus.cmd_valid & r_cmd_ready;
    assign w_op     = op_t'(bus.cmd_op);
    assign w_wait_n = bus.cmd_wdata[WAIT_W-1:0];

    // A wait of N cycles loads N-1; N=0 is treated as N=1.
    assign w_wait_load = (w_wait_n == '0) ? '0 : CNT_W'(w_wait_n - WAIT_W'(1));

    assign w_cnt_load = ((r_state == ST_IDLE) && w_hs && (w_op == OP_WAIT)) ||
                        ((r_state == ST_ACCESS) && (r_op == OP_READ));
    assign w_cnt_val  = (r_state == ST_ACCESS) ? c_RD_LOAD : w_wait_load;
    assign w_cnt_dec  = ((r_state == ST_RDWAIT) || (r_state == ST_WAITCNT)) && !w_cnt_zero;

    intbus_delay_cnt #(
        .CNT_W      (CNT_W)
    ) u_delay_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wr    <= 1'b0;
            r_bus_rd    <= 1'b0;
        end else begin
            // Strobes and the response are single-cycle pulses by default.
            r_rsp_valid <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_rd    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_op <= w_op;
                        case (w_op)
                            OP_READ, OP_WRITE: begin
                                // Bus address/data only change for real accesses
                                // so they keep the last access values otherwise.
                                r_bus_addr  <= bus.cmd_base + bus.cmd_offset;
                                r_bus_wdata <= bus.cmd_wdata;
                                r_bus_wr    <= (w_op == OP_WRITE);
                                r_bus_rd    <= (w_op == OP_READ);
                                // A write completes in its access cycle.
                                r_rsp_valid <= (w_op == OP_WRITE);
                                r_cmd_ready <= 1'b0;
                                r_state     <= ST_ACCESS;
                            end
                            OP_WAIT: begin
                                // rsp_valid marks the last wait cycle; for N<=1
                                // that is the very first one.
                                r_rsp_valid <= (w_wait_n <= WAIT_W'(1));
                                r_cmd_ready <= 1'b0;
                                r_state     <= ST_WAITCNT;
                            end
                            default: begin
                                r_rsp_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_ACCESS: begin
                    if (r_op == OP_READ) begin
                        r_state <= ST_RDWAIT;
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_RDWAIT: begin
                    // Count reaches zero in the cycle the slave data is valid.
                    if (w_cnt_zero) begin
                        r_rsp_rdata <= bus.bus_rdata;
                        r_rsp_valid <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WAITCNT: begin
                    if (w_cnt_zero) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_rsp_valid <= w_cnt_one;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.bus_wr    = r_bus_wr;
    assign bus.bus_rd    = r_bus_rd;
endmodule
`default_nettype wire

// File: tb/tb_intbus_interf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intbus_interf
//  Description : Scoreboard bench for intbus_interf. The stimulus side pushes
//                the expected observable events (handshake, strobes, response)
//                with their cycle spacing; a negedge monitor pops and compares.
//                A small slave model returns data RD_LATENCY cycles after
//                bus_rd and garbage in every other cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intbus_interf;
    import intbus_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        hs;
        logic        wr;
        logic        rd;
        logic        rsp;
        logic        chk_addr;
        logic        chk_data;
        logic [31:0] addr;
        logic [31:0] data;
        int          ofs;      // cycles since previous event, -1 = don't care
    } ev_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   last_cyc;

    ev_t   exp_q[$];
    string name_q[$];

    logic [31:0] slave_data;
    logic        rd_d1;
    logic        rd_d2;

    intbus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    intbus_interf #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (2),
        .WAIT_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: data valid exactly two cycles after the bus_rd cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d1 <= 1'b0;
            rd_d2 <= 1'b0;
        end else begin
            rd_d1 <= bus_if.bus_rd;
            rd_d2 <= rd_d1;
        end
    end
    assign bus_if.bus_rdata = rd_d2 ? slave_data : 32'h0BAD_0BAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic hs, input logic wr, input logic rd,
                        input logic rsp, input logic ca, input logic cd,
                        input logic [31:0] a, input logic [31:0] d, input int ofs);
        ev_t e;
        e.hs = hs; e.wr = wr; e.rd = rd; e.rsp = rsp;
        e.chk_addr = ca; e.chk_data = cd;
        e.addr = a; e.data = d; e.ofs = ofs;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] base,
                        input logic [31:0] ofs, input logic [31:0] wd);
        int n;
        bus_if.cmd_op     = op;
        bus_if.cmd_base   = base;
        bus_if.cmd_offset = ofs;
        bus_if.cmd_wdata  = wd;
        bus_if.cmd_valid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.cmd_ready && n < 200);
        if (!bus_if.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_handshake: cmd_ready stuck at 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen, required 0", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: one event per cycle in which anything observable happens.
    ev_t         m_e;
    string       m_n;
    logic [31:0] m_act;
    int          m_d;
    logic        m_hs;
    logic        m_ok;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            m_hs = bus_if.cmd_valid && bus_if.cmd_ready;
            if (m_hs || bus_if.bus_wr || bus_if.bus_rd || bus_if.rsp_valid) begin
                m_d = cyc - last_cyc;
                last_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got hs=%0b wr=%0b rd=%0b rsp=%0b, required no event",
                             m_hs, bus_if.bus_wr, bus_if.bus_rd, bus_if.rsp_valid);
                end else begin
                    m_e = exp_q.pop_front();
                    m_n = name_q.pop_front();
                    m_act = m_e.wr ? bus_if.bus_wdata : bus_if.rsp_rdata;
                    m_ok = (m_hs == m_e.hs) && (bus_if.bus_wr == m_e.wr) &&
                           (bus_if.bus_rd == m_e.rd) && (bus_if.rsp_valid == m_e.rsp) &&
                           (!m_e.chk_addr || bus_if.bus_addr == m_e.addr) &&
                           (!m_e.chk_data || m_act == m_e.data) &&
                           (m_e.ofs < 0 || m_d == m_e.ofs);
                    if (!m_ok) begin
                        errors++;
                        $display("FAIL %s: got hs=%0b wr=%0b rd=%0b rsp=%0b addr=%h data=%h dly=%0d, required hs=%0b wr=%0b rd=%0b rsp=%0b addr=%h data=%h dly=%0d",
                                 m_n, m_hs, bus_if.bus_wr, bus_if.bus_rd, bus_if.rsp_valid,
                                 bus_if.bus_addr, m_act, m_d, m_e.hs, m_e.wr, m_e.rd, m_e.rsp,
                                 m_e.addr, m_e.data, m_e.ofs);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        last_cyc = 0;
        slave_data = 32'h0;
        bus_if.cmd_valid  = 1'b0;
        bus_if.cmd_op     = 2'b11;
        bus_if.cmd_base   = '0;
        bus_if.cmd_offset = '0;
        bus_if.cmd_wdata  = '0;

        // Reset / init state
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_bus_addr",  bus_if.bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        chk("rst_bus_wr",    32'(bus_if.bus_wr), 32'h0);
        chk("rst_bus_rd",    32'(bus_if.bus_rd), 32'h0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'h0);
        chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'h1);
        @(posedge clk);
        #1;

        // READ from the performance counter block, latency 2
        slave_data = 32'hA5A5_0001;
        push("read1_hs",  1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("read1_rd",  0, 0, 1, 0, 1, 0, 32'h1006_0000, 32'h0, 1);
        push("read1_rsp", 0, 0, 0, 1, 0, 1, 32'h0, 32'hA5A5_0001, 3);
        send(OP_READ, AXI_PERFORMANCE_BASE, 32'h0, 32'h0);
        drain("read1_drain");

        // WRITE offset 2, response in the access cycle
        push("write1_hs", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("write1_wr", 0, 1, 0, 1, 1, 1, 32'h1006_0002, 32'h1, 1);
        send(OP_WRITE, AXI_PERFORMANCE_BASE, 32'h2, 32'h1);
        drain("write1_drain");
        chk("rdata_hold_after_write", bus_if.rsp_rdata, 32'hA5A5_0001);

        // WAIT 5 immediately followed by a READ
        slave_data = 32'h1234_5678;
        push("wait5_hs",  1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("wait5_rsp", 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 5);
        send(OP_WAIT, 32'h0, 32'h0, 32'h0000_0005);
        push("read2_hs",  1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
        push("read2_rd",  0, 0, 1, 0, 1, 0, 32'h1006_0005, 32'h0, 1);
        push("read2_rsp", 0, 0, 0, 1, 0, 1, 32'h0, 32'h1234_5678, 3);
        send(OP_READ, AXI_PERFORMANCE_BASE, 32'h5, 32'h0);
        drain("wait5_read_drain");

        // Address wrap
        push("wrap_hs", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("wrap_wr", 0, 1, 0, 1, 1, 1, 32'h0000_0001, 32'hCAFE_F00D, 1);
        send(OP_WRITE, 32'hFFFF_FFFF, 32'h2, 32'hCAFE_F00D);
        drain("wrap_drain");
        chk("idle_hold_addr",  bus_if.bus_addr, 32'h0000_0001);
        chk("idle_hold_wdata", bus_if.bus_wdata, 32'hCAFE_F00D);

        // NOP, WAIT 0 and WAIT 1: all respond one cycle after handshake
        push("nop_hs",  1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("nop_rsp", 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1);
        send(OP_NOP, 32'h0, 32'h0, 32'h0);
        drain("nop_drain");
        push("wait0_hs",  1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("wait0_rsp", 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1);
        send(OP_WAIT, 32'h0, 32'h0, 32'hFFFF_0000);
        drain("wait0_drain");
        push("wait1_hs",  1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("wait1_rsp", 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1);
        send(OP_WAIT, 32'h0, 32'h0, 32'h0000_0001);
        drain("wait1_drain");

        // Reset during RDWAIT aborts the read
        slave_data = 32'h7777_7777;
        push("abort_hs", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("abort_rd", 0, 0, 1, 0, 1, 0, 32'h0000_0040, 32'h0, 1);
        send(OP_READ, 32'h0000_0040, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_bus_rd",    32'(bus_if.bus_rd), 32'h0);
        chk("abort_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
        chk("abort_rsp_rdata", bus_if.rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_cmd_ready", 32'(bus_if.cmd_ready), 32'h1);
        drain("abort_drain");
        chk("abort_rdata_after", bus_if.rsp_rdata, 32'h0);

        // Recovery read after the abort
        slave_data = 32'h0F0F_0F0F;
        push("read3_hs",  1, 0, 0, 0, 0, 0, 32'h0, 32'h0, -1);
        push("read3_rd",  0, 0, 1, 0, 1, 0, 32'h0000_0020, 32'h0, 1);
        push("read3_rsp", 0, 0, 0, 1, 0, 1, 32'h0, 32'h0F0F_0F0F, 3);
        send(OP_READ, 32'h0, 32'h20, 32'h0);
        drain("read3_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
